fdivsqrt_iter_ctrl: RTL
=======================

// Module: fdivsqrt_iter_ctrl
// PURPOSE
//  Sequences the radix-2 divide/square-root recurrence datapath: one or more
//  chained recurrence stages per cycle, each updating residual WS/WC, thermometer
//  C and on-the-fly quotient U/UM. Accepts an operation from the execute stage,
//  loads the datapath, runs it for the required cycle count, then holds the result
//  until the memory stage consumes it. Handles special-case bypass, flush and stall.
// PARAMETERS
//  CNT_W      7   width of the iteration-cycle counter and CyclesIn
//  MAX_CYCLES 64  largest legal CyclesIn value; larger values are clamped
// PORTS
//  clk          in   1      clock
//  resetn       in   1      asynchronous active-low reset
//  StartE       in   1      request: new div/sqrt operation in Execute
//  SpecialCaseE in   1      NaN/Inf/zero/x1 operand; no iterations needed
//  CyclesE      in   CNT_W  recurrence cycles required (precomputed per format)
//  StallM       in   1      Memory stage stalled; result must be held
//  FlushE       in   1      kill current operation
//  ReadyE       out  1      controller idle, StartE will be accepted
//  InitE        out  1      select initial residual/C/U/UM into state regs
//  IterEn       out  1      enable WS/WC/C/U/UM registers for one recurrence step
//  BusyE        out  1      operation in flight (stall Execute)
//  DoneM        out  1      result valid in U/UM; held while StallM
//  CycleCnt     out  CNT_W  remaining iteration cycles (debug/perf)
// BEHAVIOUR
//  - States IDLE, BUSY, DONE. Reset (resetn=0, async): IDLE, CycleCnt=0,
//    ReadyE=1, InitE=0, IterEn=0, BusyE=0, DoneM=0. Reset mid-op aborts silently.
//  - IDLE: ReadyE=1. Accept when StartE & ~FlushE. In accept cycle InitE=1
//    (comb.), IterEn=1 so init values load. Next state:
//    SpecialCaseE | CyclesE==0 -> DONE, CycleCnt=0;
//    else BUSY, CycleCnt=min(CyclesE,MAX_CYCLES).
//  - BUSY: BusyE=1, IterEn=1 every cycle, CycleCnt decrements by 1.
//    When CycleCnt==1, the last step is applied this cycle -> DONE next, CycleCnt=0.
//    Exactly CyclesE IterEn cycles after the init cycle; latency accept->DoneM =
//    CyclesE+1 cycles (1 for special case).
//  - DONE: DoneM=1, BusyE=1, IterEn=0 (result frozen). Stay while StallM;
//    when ~StallM -> IDLE (DoneM high exactly 1 cycle if unstalled).
//    StartE in DONE is ignored; requester must retry in IDLE.
//  - StartE while BUSY/DONE: ignored, no state change.
//  - FlushE: any state -> IDLE next cycle, CycleCnt=0; IterEn and InitE forced 0
//    in the flush cycle; FlushE & StartE in IDLE -> not accepted.
//  - FlushE & StallM in DONE: flush wins.
//  - CycleCnt never underflows; counter saturates at 0 outside BUSY.
//  - BusyE = (state!=IDLE); ReadyE = (state==IDLE); both registered-state derived.
// TESTING
//  - Reset: resetn low mid-BUSY (CycleCnt=9) -> same cycle all outputs reset, ReadyE=1.
//  - Normal: StartE, CyclesE=13, StallM=0 -> InitE 1 cycle, IterEn 14 cycles total,
//    DoneM single pulse 14 cycles after accept, back to ReadyE.
//  - Special: StartE & SpecialCaseE, CyclesE=13 -> DoneM next cycle, IterEn only init cycle.
//  - Stall: finish with StallM=1 for 3 cycles -> DoneM held 4 cycles, IterEn=0,
//    U/UM unchanged.
//  - Flush: FlushE at CycleCnt=5 -> IDLE next cycle, no DoneM; FlushE&StartE in IDLE ignored.
//  - Clamp/boundary: CyclesE=100 -> CycleCnt loads 64; CyclesE=1 -> DoneM 2 cycles
//    after accept; StartE during BUSY ignored.

Source files
------------

// File: rtl/fdivsqrt_iter_ctrl_if.sv
// Handshake bundle between the Execute/Memory pipeline control and the
// divide/square-root iteration controller.
//   master : pipeline side. It drives StartE, SpecialCaseE, CyclesE, StallM
//            and FlushE.
//   slave  : controller side. It drives ReadyE, InitE, IterEn, BusyE, DoneM
//            and CycleCnt.
interface fdivsqrt_iter_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             StartE;
  logic             SpecialCaseE;
  logic [CNT_W-1:0] CyclesE;
  logic             StallM;
  logic             FlushE;
  logic             ReadyE;
  logic             InitE;
  logic             IterEn;
  logic             BusyE;
  logic             DoneM;
  logic [CNT_W-1:0] CycleCnt;

  modport master (
    output StartE, SpecialCaseE, CyclesE, StallM, FlushE,
    input  ReadyE, InitE, IterEn, BusyE, DoneM, CycleCnt
  );

  modport slave (
    input  StartE, SpecialCaseE, CyclesE, StallM, FlushE,
    output ReadyE, InitE, IterEn, BusyE, DoneM, CycleCnt
  );
endinterface

// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration controller for the radix-2 divide/square-root recurrence.
//
// The controller accepts an operation from Execute and loads the initial
// datapath values. It then enables the recurrence registers for the required
// number of cycles. When the recurrence finishes, it holds the result until
// Memory is no longer stalled.
//
// Ports
//   clk, resetn : clock and asynchronous active-low reset.
//   bus.slave   : StartE, SpecialCaseE, CyclesE, StallM and FlushE come in.
//                 ReadyE, InitE, IterEn, BusyE, DoneM and CycleCnt go out.
module fdivsqrt_iter_ctrl #(
  parameter int CNT_W      = 7,
  parameter int MAX_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  fdivsqrt_iter_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  function automatic logic [CNT_W-1:0] clamp_cycles(input logic [CNT_W-1:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  // Accept is qualified by resetn so that InitE/IterEn stay low while reset is
  // asserted, even if StartE happens to be high.
  assign accept = resetn && (state == IDLE) && bus.StartE && !bus.FlushE;

  // InitE and IterEn must act in the accept cycle itself, so they are
  // combinational. The status outputs come only from the registered state.
  assign bus.InitE    = accept;
  assign bus.IterEn   = accept || ((state == BUSY) && !bus.FlushE);
  assign bus.ReadyE   = (state == IDLE);
  assign bus.BusyE    = (state != IDLE);
  assign bus.DoneM    = (state == DONE);
  assign bus.CycleCnt = cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.FlushE) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.StartE) begin
            if (bus.SpecialCaseE || (bus.CyclesE == '0)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              state <= BUSY;
              cnt   <= clamp_cycles(bus.CyclesE);
            end
          end
        end
        BUSY: begin
          // A count of 1 means this cycle applies the final step. Testing <=1
          // also protects against underflow if the count were ever 0 here.
          if (cnt <= CNT_W'(1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          cnt <= '0;
          if (!bus.StallM) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
